// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin sprite ROM port arbiter with burst hold and tagged pixel return
module sprite_rom_arbiter #(
  parameter int                NUM_REQ     = 4,
  parameter int                ROW_W       = 5,
  parameter int                COL_W       = 6,
  parameter int                DATA_W      = 12,
  parameter int                MAX_BURST   = 8,
  parameter logic [DATA_W-1:0] TRANSPARENT = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*ROW_W-1:0] req_row,
  input  logic [NUM_REQ*COL_W-1:0] req_col,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [ROW_W-1:0]         rom_row,
  output logic [COL_W-1:0]         rom_col,
  input  logic [DATA_W-1:0]        rom_data,
  output logic                     rsp_valid,
  output logic [2:0]               rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_transparent
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]  owner_q;
  logic              owner_vld_q;
  logic [BCNT_W-1:0] burst_cnt_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [ROW_W-1:0]  last_row_q;
  logic [COL_W-1:0]  last_col_q;
  logic              pend_vld_q;
  logic [IDX_W-1:0]  pend_id_q;

  logic              hold;
  logic              rot_vld;
  logic [IDX_W-1:0]  rot_idx;
  logic [IDX_W-1:0]  cand;
  logic              sel_vld;
  logic [IDX_W-1:0]  sel_idx;
  logic [ROW_W-1:0]  row_mux;
  logic [COL_W-1:0]  col_mux;

  // Descending scan so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    rot_vld = 1'b0;
    rot_idx = '0;
    cand    = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      cand = IDX_W'((int'(rr_ptr_q) + j) % NUM_REQ);
      if (req[cand]) begin
        rot_vld = 1'b1;
        rot_idx = cand;
      end
    end
  end

  always_comb begin
    hold    = owner_vld_q && req[owner_q] && (burst_cnt_q < BURST_LAST);
    sel_vld = reset_n && (hold || rot_vld);
    sel_idx = hold ? owner_q : rot_idx;
    row_mux = '0;
    col_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        row_mux = req_row[i*ROW_W +: ROW_W];
        col_mux = req_col[i*COL_W +: COL_W];
      end
    end
  end

  // Idle cycles keep presenting the last granted address to the ROM.
  always_comb begin
    gnt     = '0;
    rom_row = '0;
    rom_col = '0;
    if (reset_n) begin
      if (sel_vld) begin
        gnt     = NUM_REQ'(1) << sel_idx;
        rom_row = row_mux;
        rom_col = col_mux;
      end else begin
        rom_row = last_row_q;
        rom_col = last_col_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      burst_cnt_q <= '0;
      rr_ptr_q    <= '0;
      last_row_q  <= '0;
      last_col_q  <= '0;
    end else if (sel_vld) begin
      if (hold) begin
        burst_cnt_q <= burst_cnt_q + 1'b1;
      end else begin
        owner_q     <= rot_idx;
        owner_vld_q <= 1'b1;
        burst_cnt_q <= '0;
        rr_ptr_q    <= (rot_idx == LAST_IDX) ? '0 : rot_idx + 1'b1;
      end
      last_row_q <= row_mux;
      last_col_q <= col_mux;
    end else begin
      owner_vld_q <= 1'b0;
    end
  end

  // pend_* tracks the grant whose ROM read is on rom_data this cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_vld_q      <= 1'b0;
      pend_id_q       <= '0;
      rsp_valid       <= 1'b0;
      rsp_id          <= '0;
      rsp_data        <= '0;
      rsp_transparent <= 1'b0;
    end else begin
      pend_vld_q      <= sel_vld;
      if (sel_vld) begin
        pend_id_q <= sel_idx;
      end
      rsp_valid       <= pend_vld_q;
      rsp_transparent <= pend_vld_q && (rom_data == TRANSPARENT);
      if (pend_vld_q) begin
        rsp_data <= rom_data;
        rsp_id   <= 3'(pend_id_q);
      end
    end
  end

endmodule
